// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and load responses into one register-file
// write port. It also tracks which destination registers still have a write
// outstanding, so decode can stall on operand and WAW hazards.
module writeback_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_index,
    input  logic [4:0]  rs2_index,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [4:0]  rd_index,
    output logic [31:0] rd_in,
    output logic        rd_we,
    output logic [31:0] retired_count
);

    logic        rd_we_q, rd_we_d;
    logic [4:0]  rd_index_q, rd_index_d;
    logic [31:0] rd_in_q, rd_in_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] retired_q, retired_d;

    logic        clear_hit;
    logic        ld_acc;
    logic        alu_acc;
    logic        issue_acc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    // Handshake readiness: loads always win; an issue stalls only on a live
    // reservation that is not being retired in this same cycle.
    always_comb begin
        clear_hit   = rd_we_q && (rd_index_q == issue_rd);
        ld_ready    = !rst;
        alu_ready   = !rst && !ld_valid;
        issue_ready = !rst && !((issue_rd != 5'd0) && pending_q[issue_rd] && !clear_hit);
        ld_acc      = ld_valid && ld_ready;
        alu_acc     = alu_valid && alu_ready;
        issue_acc   = issue_valid && issue_ready;
    end

    // Load data extraction; unused funct3 encodings fall back to a full word.
    always_comb begin
        case (ld_offset)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_funct3)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_value = {24'd0, ld_byte};
            3'b101:  ld_value = {16'd0, ld_half};
            default: ld_value = ld_data;
        endcase
    end

    // Next write-port contents; x0 transfers are consumed but never written.
    always_comb begin
        rd_we_d    = 1'b0;
        rd_index_d = rd_index_q;
        rd_in_d    = rd_in_q;
        if (ld_acc) begin
            rd_we_d    = (ld_rd != 5'd0);
            rd_index_d = ld_rd;
            rd_in_d    = ld_value;
        end else if (alu_acc) begin
            rd_we_d    = (alu_rd != 5'd0);
            rd_index_d = alu_rd;
            rd_in_d    = alu_data;
        end
        retired_d = retired_q + {31'd0, rd_we_d};
    end

    // Scoreboard update: clear on retire first, so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        if (rd_we_q) begin
            pending_d[rd_index_q] = 1'b0;
        end
        if (issue_acc && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; reset also kills a write that is currently on the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_we_q    <= 1'b0;
            rd_index_q <= 5'd0;
            rd_in_q    <= 32'd0;
            pending_q  <= 32'd0;
            retired_q  <= 32'd0;
        end else begin
            rd_we_q    <= rd_we_d;
            rd_index_q <= rd_index_d;
            rd_in_q    <= rd_in_d;
            pending_q  <= pending_d;
            retired_q  <= retired_d;
        end
    end

    // Output mapping; operand busy has no forwarding from the write port.
    always_comb begin
        rd_we         = rd_we_q;
        rd_index      = rd_index_q;
        rd_in         = rd_in_q;
        retired_count = retired_q;
        rs1_busy      = (rs1_index != 5'd0) && pending_q[rs1_index];
        rs2_busy      = (rs2_index != 5'd0) && pending_q[rs2_index];
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed stimulus, a reference model of the
// write port and reservations, and literal checks on key cases.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, issue_valid = 1'b0;
    logic        alu_ready, ld_ready, issue_ready;
    logic [4:0]  alu_rd = '0, ld_rd = '0, issue_rd = '0, rs1_index = '0, rs2_index = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_offset = '0;
    logic        rs1_busy, rs2_busy, rd_we;
    logic [4:0]  rd_index;
    logic [31:0] rd_in, retired_count;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_unit dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_funct3(ld_funct3), .ld_offset(ld_offset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
        .rs1_index(rs1_index), .rs2_index(rs2_index),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd_index(rd_index), .rd_in(rd_in), .rd_we(rd_we), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_pend [32];
    bit          m_we;
    logic [4:0]  m_idx;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit m_issue_ok();
        if (issue_rd == 0) return 1'b1;
        if (!m_pend[issue_rd]) return 1'b1;
        return m_we && (m_idx == issue_rd);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit ok;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] <= 1'b0;
            m_we   <= 1'b0;
            m_idx  <= '0;
            m_data <= '0;
            m_cnt  <= '0;
        end else begin
            ok = m_issue_ok();
            if (m_we) m_pend[m_idx] <= 1'b0;
            if (issue_valid && ok && issue_rd != 0) m_pend[issue_rd] <= 1'b1;
            if (ld_valid) begin
                m_we   <= (ld_rd != 0);
                m_idx  <= ld_rd;
                m_data <= m_load(ld_funct3, ld_offset, ld_data);
                m_cnt  <= m_cnt + ((ld_rd != 0) ? 1 : 0);
            end else if (alu_valid) begin
                m_we   <= (alu_rd != 0);
                m_idx  <= alu_rd;
                m_data <= alu_data;
                m_cnt  <= m_cnt + ((alu_rd != 0) ? 1 : 0);
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_we", {31'd0, rd_we}, 32'd0);
            chk("rst_idx", {27'd0, rd_index}, 32'd0);
            chk("rst_data", rd_in, 32'd0);
            chk("rst_cnt", retired_count, 32'd0);
            chk("rst_rdy", {29'd0, ld_ready, alu_ready, issue_ready}, 32'd0);
        end else begin
            chk("m_we", {31'd0, rd_we}, {31'd0, m_we});
            if (m_we) begin
                chk("m_idx", {27'd0, rd_index}, {27'd0, m_idx});
                chk("m_data", rd_in, m_data);
            end
            chk("m_cnt", retired_count, m_cnt);
            chk("m_ld_rdy", {31'd0, ld_ready}, 32'd1);
            chk("m_alu_rdy", {31'd0, alu_ready}, {31'd0, !ld_valid});
            chk("m_iss_rdy", {31'd0, issue_ready}, {31'd0, m_issue_ok()});
            chk("m_rs1", {31'd0, rs1_busy}, {31'd0, (rs1_index != 0) && m_pend[rs1_index]});
            chk("m_rs2", {31'd0, rs2_busy}, {31'd0, (rs2_index != 0) && m_pend[rs2_index]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [31:0] t_data [14] = '{32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB,
                                 32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB,
                                 32'h7F80017E, 32'h7F80017E, 32'h7F80017E, 32'h7F80017E,
                                 32'h7F80017E, 32'h7F80017E};
    logic [2:0]  t_f    [14] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7,
                                 3'd0, 3'd0, 3'd0, 3'd4, 3'd5, 3'd1};
    logic [1:0]  t_off  [14] = '{2'd2, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                                 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [31:0] t_exp  [14] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFAABB, 32'h00008899,
                                 32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB,
                                 32'h0000007E, 32'h00000001, 32'hFFFFFF80, 32'h0000007F,
                                 32'h0000017E, 32'h00007F80};

    initial begin
        logic [31:0] cbase;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_iss_rdy", {31'd0, issue_ready}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // First handshake right after reset release; ALU write to x5.
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cyc();
        alu_valid = 0;
        chk("alu_idx", {27'd0, rd_index}, 32'd5);
        chk("alu_data", rd_in, 32'hDEADBEEF);
        chk("alu_we", {31'd0, rd_we}, 32'd1);
        chk("alu_cnt", retired_count, 32'd1);
        cyc();
        chk("we_drop", {31'd0, rd_we}, 32'd0);
        chk("idx_hold", {27'd0, rd_index}, 32'd5);
        chk("data_hold", rd_in, 32'hDEADBEEF);

        // Back-to-back loads covering every extraction mode.
        for (int i = 0; i < 14; i++) begin
            ld_valid = 1; ld_rd = 5'(10 + i); ld_data = t_data[i];
            ld_funct3 = t_f[i]; ld_offset = t_off[i];
            cyc();
            chk("load_val", rd_in, t_exp[i]);
        end
        ld_valid = 0;
        cyc();

        // Load and ALU collide: load first, ALU held then written.
        ld_valid = 1; ld_rd = 1; ld_data = 32'h11223344; ld_funct3 = 3'd2; ld_offset = 2'd0;
        alu_valid = 1; alu_rd = 2; alu_data = 32'h55667788;
        #1;
        chk("alu_stall", {31'd0, alu_ready}, 32'd0);
        cyc();
        ld_valid = 0;
        chk("pri_ld_idx", {27'd0, rd_index}, 32'd1);
        chk("pri_ld_data", rd_in, 32'h11223344);
        #1;
        chk("alu_release", {31'd0, alu_ready}, 32'd1);
        cyc();
        alu_valid = 0;
        chk("pri_alu_idx", {27'd0, rd_index}, 32'd2);
        chk("pri_alu_data", rd_in, 32'h55667788);

        // Reservation of x7, WAW stall, release on retire with set winning.
        issue_valid = 1; issue_rd = 7;
        #1;
        chk("iss7_rdy", {31'd0, issue_ready}, 32'd1);
        cyc();
        issue_valid = 0; rs1_index = 7;
        #1;
        chk("rs1_busy7", {31'd0, rs1_busy}, 32'd1);
        issue_valid = 1; issue_rd = 7;
        #1;
        chk("waw_stall", {31'd0, issue_ready}, 32'd0);
        cyc();
        chk("waw_stall2", {31'd0, issue_ready}, 32'd0);
        alu_valid = 1; alu_rd = 7; alu_data = 32'hA5A5A5A5;
        cyc();
        alu_valid = 0;
        chk("waw_clear_rdy", {31'd0, issue_ready}, 32'd1);
        chk("waw_busy", {31'd0, rs1_busy}, 32'd1);
        cyc();
        issue_valid = 0;
        chk("set_wins", {31'd0, rs1_busy}, 32'd1);
        alu_valid = 1; alu_rd = 7; alu_data = 32'h0F0F0F0F;
        cyc();
        alu_valid = 0;
        cyc();
        chk("x7_free", {31'd0, rs1_busy}, 32'd0);

        // Writes and reservations to x0 do nothing visible.
        cbase = m_cnt;
        alu_valid = 1; alu_rd = 0; alu_data = 32'h12345678;
        cyc();
        alu_valid = 0;
        chk("x0_we", {31'd0, rd_we}, 32'd0);
        chk("x0_cnt", retired_count, cbase);
        issue_valid = 1; issue_rd = 0;
        #1;
        chk("x0_iss_rdy", {31'd0, issue_ready}, 32'd1);
        cyc();
        issue_valid = 0; rs1_index = 0;
        #1;
        chk("x0_busy", {31'd0, rs1_busy}, 32'd0);

        // Reset mid-write with x3/x9 reserved.
        issue_valid = 1; issue_rd = 3;
        cyc();
        issue_rd = 9;
        cyc();
        issue_valid = 0; rs1_index = 3; rs2_index = 9;
        #1;
        chk("pend3", {31'd0, rs1_busy}, 32'd1);
        chk("pend9", {31'd0, rs2_busy}, 32'd1);
        alu_valid = 1; alu_rd = 12; alu_data = 32'h00000001;
        cyc();
        alu_valid = 0;
        chk("pre_rst_we", {31'd0, rd_we}, 32'd1);
        #2;
        rst = 1;
        #1;
        chk("async_we", {31'd0, rd_we}, 32'd0);
        chk("async_rs1", {31'd0, rs1_busy}, 32'd0);
        chk("async_rs2", {31'd0, rs2_busy}, 32'd0);
        chk("async_cnt", retired_count, 32'd0);
        @(negedge clk);
        #2;
        rst = 0;
        ld_valid = 1; ld_rd = 4; ld_data = 32'hCAFEF00D; ld_funct3 = 3'd2; ld_offset = 2'd1;
        cyc();
        ld_valid = 0;
        chk("post_rst_we", {31'd0, rd_we}, 32'd1);
        chk("post_rst_data", rd_in, 32'hCAFEF00D);
        chk("post_rst_cnt", retired_count, 32'd1);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
